// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush sequencer: merges hazard stalls with exception flush, drains AXI, then redirects the PC.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
    parameter int unsigned     PC_W      = 64,
    parameter logic [PC_W-1:0] RESET_PC  = PC_W'(64'h8000_0000),
    parameter int unsigned     DRAIN_MAX = 255
) (
    input  logic            cpu_clk_50M,
    input  logic            cpu_rst,
    input  logic            if_stall_req,
    input  logic            id_stall_req,
    input  logic            mem_stall_req,
    input  logic            excep_flush,
    input  logic [PC_W-1:0] excep_flush_pc,
    input  logic            if_axi_busy,
    input  logic            mem_axi_busy,
    output logic [4:0]      stall,
    output logic [4:0]      flush,
    output logic            discard_fetch,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            drain_timeout,
    output logic [63:0]     perf_stall_cyc,
    output logic [63:0]     perf_flush_cnt
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        FLUSH_DRAIN = 2'd1,
        REDIRECT    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              timeout_q, timeout_d;
    logic              flush_accept;
    logic              busy;

    assign busy = if_axi_busy | mem_axi_busy;

    // State, drain counter, latched trap PC and sticky timeout
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            pc_q      <= RESET_PC;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_d           = pc_q;
        timeout_d      = timeout_q;
        stall          = 5'b00000;
        flush          = 5'b00000;
        discard_fetch  = 1'b0;
        redirect_valid = 1'b0;
        flush_accept   = 1'b0;

        case (state_q)
            RUN: begin
                if (excep_flush) begin
                    flush        = 5'b11110;
                    pc_d         = excep_flush_pc;
                    flush_accept = 1'b1;
                    cnt_d        = '0;
                    state_d      = busy ? FLUSH_DRAIN : REDIRECT;
                end else if (mem_stall_req) begin
                    stall = 5'b01111;
                    flush = 5'b10000;
                end else if (id_stall_req) begin
                    stall = 5'b00011;
                    flush = 5'b00100;
                end else if (if_stall_req) begin
                    stall = 5'b00001;
                    flush = 5'b00010;
                end
            end

            FLUSH_DRAIN: begin
                stall         = 5'b00001;
                flush         = 5'b11110;
                discard_fetch = if_axi_busy;
                if (excep_flush) begin
                    pc_d         = excep_flush_pc;
                    flush_accept = 1'b1;
                    cnt_d        = '0;
                    state_d      = busy ? FLUSH_DRAIN : REDIRECT;
                end else if (!busy) begin
                    cnt_d   = '0;
                    state_d = REDIRECT;
                end else if (cnt_q == DRAIN_LAST) begin
                    // this cycle completes DRAIN_MAX drain cycles with the bus still busy
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = REDIRECT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            REDIRECT: begin
                flush = 5'b11110;
                if (excep_flush) begin
                    // a newer trap supersedes the pending redirect
                    pc_d         = excep_flush_pc;
                    flush_accept = 1'b1;
                    cnt_d        = '0;
                    state_d      = busy ? FLUSH_DRAIN : REDIRECT;
                end else begin
                    redirect_valid = 1'b1;
                    state_d        = RUN;
                end
            end

            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        if (cpu_rst) begin
            stall          = 5'b00000;
            flush          = 5'b11111;
            discard_fetch  = 1'b0;
            redirect_valid = 1'b0;
        end
    end

    assign redirect_pc   = pc_q;
    assign drain_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [63:0] perf_stall_q;
    logic [63:0] perf_flush_q;

    // Free-running event counters, wrap modulo 2^64
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (|stall)
                perf_stall_q <= perf_stall_q + 64'd1;
            if (flush_accept)
                perf_flush_q <= perf_flush_q + 64'd1;
        end
    end

    assign perf_stall_cyc = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    logic unused_perf;
    assign unused_perf    = flush_accept;
    assign perf_stall_cyc = 64'd0;
    assign perf_flush_cnt = 64'd0;
`endif

endmodule
